// File: rtl/stack_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : stack_sequencer
// Purpose  : Opcode-driven push/pop controller for a small LIFO with
//            overflow/underflow rejection and occupancy tracking.
// Revision : 1.0
// ============================================================================
module stack_sequencer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             stk_push,
  output logic             stk_pop,
  output logic [WIDTH-1:0] stk_wdata,
  input  logic [WIDTH-1:0] stk_rdata,
  output logic             done,
  output logic             err,
  output logic [CW-1:0]    depth
);

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_PUSH = 3'd1;
  localparam logic [2:0] OP_POP  = 3'd2;
  localparam logic [2:0] OP_DUP  = 3'd3;
  localparam logic [2:0] OP_ADD  = 3'd4;
  localparam logic [2:0] OP_SUB  = 3'd5;
  localparam logic [2:0] OP_AND  = 3'd6;
  localparam logic [2:0] OP_XOR  = 3'd7;

  localparam logic [CW-1:0] DEPTH_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] DEPTH_ONE  = CW'(1);
  localparam logic [CW-1:0] DEPTH_TWO  = CW'(2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_POP_A = 2'd1,
    S_POP_B = 2'd2,
    S_PUSH  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    depth_q, depth_d;
  logic             err_q, err_d;

  logic w_accept;
  logic w_empty;
  logic w_full;

  // Second-from-top is the left operand, so SUB yields b - a.
  function automatic logic [WIDTH-1:0] alu(input logic [2:0]       op,
                                           input logic [WIDTH-1:0] lhs,
                                           input logic [WIDTH-1:0] rhs);
    logic [WIDTH-1:0] r;
    case (op)
      OP_ADD:  r = lhs + rhs;
      OP_SUB:  r = lhs - rhs;
      OP_AND:  r = lhs & rhs;
      OP_XOR:  r = lhs ^ rhs;
      default: r = '0;
    endcase
    return r;
  endfunction

  assign w_accept = cmd_valid && (state_q == S_IDLE);
  assign w_empty  = (depth_q == '0);
  assign w_full   = (depth_q == DEPTH_FULL);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    depth_d = depth_q;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          case (cmd_op)
            OP_NOP: begin
            end
            OP_PUSH: begin
              if (w_full) begin
                err_d = 1'b1;
              end else begin
                op_d    = cmd_op;
                res_d   = cmd_data;
                state_d = S_PUSH;
              end
            end
            OP_DUP: begin
              if (w_empty || w_full) begin
                err_d = 1'b1;
              end else begin
                op_d    = cmd_op;
                res_d   = stk_rdata;
                state_d = S_PUSH;
              end
            end
            OP_POP: begin
              if (w_empty) begin
                err_d = 1'b1;
              end else begin
                op_d    = cmd_op;
                state_d = S_POP_A;
              end
            end
            default: begin
              if (depth_q < DEPTH_TWO) begin
                err_d = 1'b1;
              end else begin
                op_d    = cmd_op;
                state_d = S_POP_A;
              end
            end
          endcase
        end
      end
      S_POP_A: begin
        a_d     = stk_rdata;
        depth_d = depth_q - DEPTH_ONE;
        state_d = (op_q == OP_POP) ? S_IDLE : S_POP_B;
      end
      S_POP_B: begin
        b_d     = stk_rdata;
        res_d   = alu(op_q, stk_rdata, a_q);
        depth_d = depth_q - DEPTH_ONE;
        state_d = S_PUSH;
      end
      S_PUSH: begin
        depth_d = depth_q + DEPTH_ONE;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_NOP;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      depth_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      depth_q <= depth_d;
      err_q   <= err_d;
    end
  end

  // All handshake and strobe outputs decode registered state only.
  assign cmd_ready = (state_q == S_IDLE);
  assign stk_push  = (state_q == S_PUSH);
  assign stk_pop   = (state_q == S_POP_A) || (state_q == S_POP_B);
  assign done      = (state_q == S_PUSH) || ((state_q == S_POP_A) && (op_q == OP_POP));
  assign stk_wdata = res_q;
  assign err       = err_q;
  assign depth     = depth_q;

endmodule
`default_nettype wire

// File: tb/tb_stack_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_stack_sequencer
// Purpose  : Directed self-checking bench with a behavioural 4-entry LIFO.
// Revision : 1.0
// ============================================================================
module tb_stack_sequencer;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic             clock;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic             stk_push;
  logic             stk_pop;
  logic [WIDTH-1:0] stk_wdata;
  logic [WIDTH-1:0] stk_rdata;
  logic             done;
  logic             err;
  logic [CW-1:0]    depth;

  int errors = 0;
  int checks = 0;
  int push_cnt = 0, pop_cnt = 0, done_cnt = 0, err_cnt = 0;
  int p0, q0, d0, e0;

  stack_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) dut (
    .clock     (clock),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .stk_push  (stk_push),
    .stk_pop   (stk_pop),
    .stk_wdata (stk_wdata),
    .stk_rdata (stk_rdata),
    .done      (done),
    .err       (err),
    .depth     (depth)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural LIFO sharing the sequencer reset.
  logic [WIDTH-1:0] mem [DEPTH];
  int sp = 0;
  always @(posedge clock) begin
    if (reset) begin
      sp <= 0;
    end else if (stk_push && sp < DEPTH) begin
      mem[sp] <= stk_wdata;
      sp      <= sp + 1;
    end else if (stk_pop && sp > 0) begin
      sp <= sp - 1;
    end
  end
  assign stk_rdata = (sp == 0) ? '0 : mem[sp-1];

  always @(negedge clock) begin
    if (!reset) begin
      push_cnt += int'(stk_push);
      pop_cnt  += int'(stk_pop);
      done_cnt += int'(done);
      err_cnt  += int'(err);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic snap();
    p0 = push_cnt; q0 = pop_cnt; d0 = done_cnt; e0 = err_cnt;
  endtask

  // Offer a command, wait for acceptance, return 1 time unit after the accept edge.
  task automatic send(input logic [2:0] op, input logic [WIDTH-1:0] d);
    int t = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    while (!cmd_ready && t < 20) begin
      tick();
      t++;
    end
    chk("send_ready", 32'(cmd_ready), 32'd1);
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    tick();
    while (!cmd_ready && t < 20) begin
      tick();
      t++;
    end
    chk("idle_timeout", 32'(cmd_ready), 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_data = '0;
    do_reset();

    // Reset state
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_depth", 32'(depth), 32'd0);
    chk("rst_strobes", {29'd0, stk_push, stk_pop, done}, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_wdata", 32'(stk_wdata), 32'd0);

    // 1: two back-to-back pushes
    snap();
    send(3'd1, 16'h0003);
    send(3'd1, 16'h0005);
    wait_idle();
    chk("t1_push_cnt", 32'(push_cnt - p0), 32'd2);
    chk("t1_done_cnt", 32'(done_cnt - d0), 32'd2);
    chk("t1_depth", 32'(depth), 32'd2);
    chk("t1_top", 32'(stk_rdata), 32'h0005);

    // 2: SUB is second-from-top minus top: 3 - 5
    send(3'd5, 16'h0);
    tick();
    chk("t2_n1_pop", 32'(stk_pop), 32'd1);
    chk("t2_n1_ready", 32'(cmd_ready), 32'd0);
    chk("t2_n1_push", 32'(stk_push), 32'd0);
    tick();
    chk("t2_n2_pop", 32'(stk_pop), 32'd1);
    chk("t2_n2_ready", 32'(cmd_ready), 32'd0);
    tick();
    chk("t2_n3_push", 32'(stk_push), 32'd1);
    chk("t2_n3_pop", 32'(stk_pop), 32'd0);
    chk("t2_n3_wdata", 32'(stk_wdata), 32'h0000FFFE);
    chk("t2_n3_done", 32'(done), 32'd1);
    chk("t2_n3_ready", 32'(cmd_ready), 32'd0);
    tick();
    chk("t2_n4_ready", 32'(cmd_ready), 32'd1);
    chk("t2_depth", 32'(depth), 32'd1);
    chk("t2_top", 32'(stk_rdata), 32'h0000FFFE);

    // 3: ADD wraps, then a binary op at depth 1 is rejected
    do_reset();
    send(3'd1, 16'hFFFF);
    send(3'd1, 16'h0002);
    send(3'd4, 16'h0);
    wait_idle();
    chk("t3_add_top", 32'(stk_rdata), 32'h0001);
    chk("t3_add_depth", 32'(depth), 32'd1);
    snap();
    send(3'd7, 16'h0);
    tick();
    chk("t3_xor_err", 32'(err), 32'd1);
    chk("t3_xor_pop", 32'(stk_pop), 32'd0);
    chk("t3_xor_ready", 32'(cmd_ready), 32'd1);
    chk("t3_xor_depth", 32'(depth), 32'd1);
    tick();
    chk("t3_err_once", 32'(err), 32'd0);
    chk("t3_no_pop", 32'(pop_cnt - q0), 32'd0);

    // 4: overflow and underflow
    send(3'd2, 16'h0);
    wait_idle();
    chk("t4_empty", 32'(depth), 32'd0);
    snap();
    for (int i = 1; i <= 5; i++) begin
      send(3'd1, 16'(i * 16'h0011));
      wait_idle();
    end
    chk("t4_full_depth", 32'(depth), 32'd4);
    chk("t4_full_top", 32'(stk_rdata), 32'h0044);
    chk("t4_push_cnt", 32'(push_cnt - p0), 32'd4);
    chk("t4_ovf_err", 32'(err_cnt - e0), 32'd1);
    send(3'd3, 16'h0);
    tick();
    chk("t4_dup_err", 32'(err), 32'd1);
    chk("t4_dup_push", 32'(stk_push), 32'd0);
    snap();
    for (int i = 0; i < 4; i++) begin
      send(3'd2, 16'h0);
      wait_idle();
    end
    chk("t4_pop_depth", 32'(depth), 32'd0);
    chk("t4_pop_cnt", 32'(pop_cnt - q0), 32'd4);
    chk("t4_pop_done", 32'(done_cnt - d0), 32'd4);
    send(3'd2, 16'h0);
    tick();
    chk("t4_udf_err", 32'(err), 32'd1);
    chk("t4_udf_pop", 32'(stk_pop), 32'd0);
    chk("t4_udf_depth", 32'(depth), 32'd0);

    // 5: DUP then AND of equal words; NOP has no side effects
    send(3'd1, 16'h1234);
    send(3'd3, 16'hFFFF);
    tick();
    chk("t5_dup_wdata", 32'(stk_wdata), 32'h1234);
    wait_idle();
    chk("t5_dup_depth", 32'(depth), 32'd2);
    send(3'd6, 16'h0);
    wait_idle();
    chk("t5_and_top", 32'(stk_rdata), 32'h1234);
    chk("t5_and_depth", 32'(depth), 32'd1);
    snap();
    send(3'd0, 16'hABCD);
    tick();
    chk("t5_nop_ready", 32'(cmd_ready), 32'd1);
    chk("t5_nop_quiet", {28'd0, stk_push, stk_pop, done, err}, 32'd0);
    chk("t5_nop_depth", 32'(depth), 32'd1);
    chk("t5_nop_cnts", 32'((push_cnt - p0) + (pop_cnt - q0) + (done_cnt - d0)), 32'd0);

    // 6: reset during the second pop of an ADD
    send(3'd1, 16'h0007);
    send(3'd1, 16'h0009);
    wait_idle();
    chk("t6_pre_depth", 32'(depth), 32'd3);
    snap();
    send(3'd4, 16'h0);
    tick();
    tick();
    chk("t6_popb", 32'(stk_pop), 32'd1);
    reset = 1'b1;
    tick();
    chk("t6_rst_push", 32'(stk_push), 32'd0);
    chk("t6_rst_depth", 32'(depth), 32'd0);
    chk("t6_rst_done", 32'(done), 32'd0);
    chk("t6_rst_ready", 32'(cmd_ready), 32'd1);
    reset = 1'b0;
    repeat (3) tick();
    chk("t6_no_push", 32'(push_cnt - p0), 32'd0);
    chk("t6_depth_hold", 32'(depth), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
